// File: rtl/level_sequencer.sv
// level_sequencer
//   Tracks the current level, the score needed to leave it and a per-level
//   countdown. Drives a multi-cycle hero reset, one-cycle level-up and
//   timeout pulses, and holds a "game complete" state until restart.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   tick_i            one-cycle timebase strobe
//   restart_i         one-cycle restart strobe (only acted on in COMPLETE)
//   score_i           current score
//   hero_x_pos_i      packed x {previous, current}
//   hero_y_pos_i      packed y {previous, current}
//   level_o           current level, 0-based
//   hero_rst_o        hero reposition request
//   score_req_o       score needed to exit the current level
//   level_up_o        one-cycle pulse on level advance / final clear
//   time_out_o        one-cycle pulse on countdown expiry
//   game_done_o       high while in COMPLETE
//   time_left_o       remaining ticks
module level_sequencer #(
  parameter int unsigned COORD_W    = 12,
  parameter int unsigned SCORE_W    = 24,
  parameter int unsigned LEVEL_W    = 10,
  parameter int unsigned TIMER_W    = 16,
  parameter int unsigned EXIT_X     = 482,
  parameter int unsigned EXIT_Y     = 108,
  parameter int unsigned SCORE_STEP = 1000,
  parameter int unsigned MAX_LEVEL  = 8,
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned TIME_LIMIT = 3000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick_i,
  input  logic                 restart_i,
  input  logic [SCORE_W-1:0]   score_i,
  input  logic [2*COORD_W-1:0] hero_x_pos_i,
  input  logic [2*COORD_W-1:0] hero_y_pos_i,
  output logic [LEVEL_W-1:0]   level_o,
  output logic                 hero_rst_o,
  output logic [SCORE_W-1:0]   score_req_o,
  output logic                 level_up_o,
  output logic                 time_out_o,
  output logic                 game_done_o,
  output logic [TIMER_W-1:0]   time_left_o
);

  localparam int unsigned HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [COORD_W-1:0] EX        = COORD_W'(EXIT_X);
  localparam logic [COORD_W-1:0] EY        = COORD_W'(EXIT_Y);
  localparam logic [SCORE_W-1:0] STEP      = SCORE_W'(SCORE_STEP);
  localparam logic [TIMER_W-1:0] TLIM      = TIMER_W'(TIME_LIMIT);
  localparam logic [LEVEL_W-1:0] LAST      = LEVEL_W'(MAX_LEVEL - 1);
  localparam logic [HOLD_W-1:0]  HOLD_INIT = HOLD_W'(RST_CYCLES - 1);
  localparam bit                 TIMER_EN  = (TIME_LIMIT != 0);

  typedef enum logic [1:0] {S_PLAY, S_HOLD, S_COMPLETE} state_e;

  state_e              state_q, state_d;
  logic [LEVEL_W-1:0]  level_q, level_d;
  logic                hero_rst_q, hero_rst_d;
  logic [SCORE_W-1:0]  score_req_q, score_req_d;
  logic                level_up_q, level_up_d;
  logic                time_out_q, time_out_d;
  logic                game_done_q, game_done_d;
  logic [TIMER_W-1:0]  time_left_q, time_left_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;

  // Exit requires the hero to have been on the exit tile for two samples
  // (previous and current fields) so a pass-through does not count.
  logic exit_hit;
  assign exit_hit = (hero_x_pos_i[2*COORD_W-1:COORD_W] == EX) &&
                    (hero_x_pos_i[COORD_W-1:0]         == EX) &&
                    (hero_y_pos_i[2*COORD_W-1:COORD_W] == EY) &&
                    (hero_y_pos_i[COORD_W-1:0]         == EY) &&
                    (score_i >= score_req_q);

  logic expire;
  assign expire = TIMER_EN && tick_i && (time_left_q == TIMER_W'(1));

  // Next requirement saturates instead of wrapping to a tiny value.
  logic [SCORE_W:0]   req_sum;
  logic [SCORE_W-1:0] req_sat;
  assign req_sum = {1'b0, score_i} + {1'b0, STEP};
  assign req_sat = req_sum[SCORE_W] ? '1 : req_sum[SCORE_W-1:0];

  // State register plus registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_PLAY;
      level_q     <= '0;
      hero_rst_q  <= 1'b0;
      score_req_q <= STEP;
      level_up_q  <= 1'b0;
      time_out_q  <= 1'b0;
      game_done_q <= 1'b0;
      time_left_q <= TLIM;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      hero_rst_q  <= hero_rst_d;
      score_req_q <= score_req_d;
      level_up_q  <= level_up_d;
      time_out_q  <= time_out_d;
      game_done_q <= game_done_d;
      time_left_q <= time_left_d;
      hold_q      <= hold_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_PLAY: begin
        if (exit_hit)    state_d = (level_q < LAST) ? S_HOLD : S_COMPLETE;
        else if (expire) state_d = S_HOLD;
      end
      S_HOLD:     if (hold_q == '0) state_d = S_PLAY;
      S_COMPLETE: if (restart_i)    state_d = S_HOLD;
      default:    state_d = S_PLAY;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    level_d     = level_q;
    hero_rst_d  = hero_rst_q;
    score_req_d = score_req_q;
    level_up_d  = 1'b0;
    time_out_d  = 1'b0;
    game_done_d = game_done_q;
    time_left_d = time_left_q;
    hold_d      = hold_q;
    unique case (state_q)
      S_PLAY: begin
        // Exit takes priority over a simultaneous expiry; timer is not
        // touched on exit since HOLD reloads it on the way out.
        if (exit_hit) begin
          level_up_d = 1'b1;
          hero_rst_d = 1'b1;
          if (level_q < LAST) begin
            level_d     = level_q + LEVEL_W'(1);
            score_req_d = req_sat;
            hold_d      = HOLD_INIT;
          end else begin
            game_done_d = 1'b1;
          end
        end else if (expire) begin
          time_out_d  = 1'b1;
          time_left_d = TLIM;
          hero_rst_d  = 1'b1;
          hold_d      = HOLD_INIT;
        end else if (TIMER_EN && tick_i) begin
          time_left_d = time_left_q - TIMER_W'(1);
        end
      end
      S_HOLD: begin
        // hero_rst was raised on entry; RST_CYCLES-1 further cycles here.
        if (hold_q == '0) begin
          hero_rst_d  = 1'b0;
          time_left_d = TLIM;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      S_COMPLETE: begin
        hero_rst_d = 1'b0;
        if (restart_i) begin
          level_d     = '0;
          score_req_d = req_sat;
          time_left_d = TLIM;
          game_done_d = 1'b0;
          hero_rst_d  = 1'b1;
          hold_d      = HOLD_INIT;
        end
      end
      default: ;
    endcase
  end

  assign level_o     = level_q;
  assign hero_rst_o  = hero_rst_q;
  assign score_req_o = score_req_q;
  assign level_up_o  = level_up_q;
  assign time_out_o  = time_out_q;
  assign game_done_o = game_done_q;
  assign time_left_o = time_left_q;

endmodule

// File: tb/tb_level_sequencer.sv
// Scoreboard bench for level_sequencer: stimulus pushes the hand-derived
// expected outputs for each cycle; a monitor pops and compares them.
module tb_level_sequencer;

  localparam int COORD_W = 12;
  localparam int SCORE_W = 24;
  localparam int LEVEL_W = 10;
  localparam int TIMER_W = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 tick, restart;
  logic [SCORE_W-1:0]   score;
  logic [2*COORD_W-1:0] xpos, ypos;
  logic [LEVEL_W-1:0]   level;
  logic                 hero_rst, level_up, time_out, game_done;
  logic [SCORE_W-1:0]   score_req;
  logic [TIMER_W-1:0]   time_left;

  always #5 clk = ~clk;

  level_sequencer #(
    .COORD_W(COORD_W), .SCORE_W(SCORE_W), .LEVEL_W(LEVEL_W), .TIMER_W(TIMER_W),
    .EXIT_X(482), .EXIT_Y(108), .SCORE_STEP(1000), .MAX_LEVEL(4),
    .RST_CYCLES(4), .TIME_LIMIT(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick_i(tick), .restart_i(restart),
    .score_i(score), .hero_x_pos_i(xpos), .hero_y_pos_i(ypos),
    .level_o(level), .hero_rst_o(hero_rst), .score_req_o(score_req),
    .level_up_o(level_up), .time_out_o(time_out), .game_done_o(game_done),
    .time_left_o(time_left)
  );

  typedef struct packed {
    logic [LEVEL_W-1:0] lv;
    logic               hr;
    logic [SCORE_W-1:0] rq;
    logic               lu;
    logic               to;
    logic               gd;
    logic [TIMER_W-1:0] tl;
  } out_t;

  out_t  exp_q[$];
  string nm_q[$];
  out_t  e;
  out_t  RST;
  int    n_vec = 0;
  int    n_bad = 0;
  event  chk_ev;

  // Monitor: compares on every falling edge (or an explicit mid-cycle check)
  always begin
    out_t  a, x;
    string n;
    @(negedge clk or chk_ev);
    if (exp_q.size() != 0) begin
      x = exp_q.pop_front();
      n = nm_q.pop_front();
      a = '{lv:level, hr:hero_rst, rq:score_req, lu:level_up, to:time_out,
            gd:game_done, tl:time_left};
      n_vec++;
      if (a !== x) begin
        n_bad++;
        $display("FAIL %s: got lv=%0d hr=%b rq=%h lu=%b to=%b gd=%b tl=%0d, want lv=%0d hr=%b rq=%h lu=%b to=%b gd=%b tl=%0d",
                 n, a.lv, a.hr, a.rq, a.lu, a.to, a.gd, a.tl,
                 x.lv, x.hr, x.rq, x.lu, x.to, x.gd, x.tl);
      end
    end
  end

  // pos: 0 away from exit, 1 on exit (both fields), 2 previous x off by one
  task automatic drv(input logic t, input logic r, input logic [SCORE_W-1:0] s,
                     input int pos);
    @(negedge clk); #1;
    tick = t; restart = r; score = s;
    case (pos)
      1:       begin xpos = {12'd482, 12'd482}; ypos = {12'd108, 12'd108}; end
      2:       begin xpos = {12'd481, 12'd482}; ypos = {12'd108, 12'd108}; end
      default: begin xpos = '0; ypos = '0; end
    endcase
  endtask

  task automatic push(input string n);
    exp_q.push_back(e);
    nm_q.push_back(n);
  endtask

  task automatic hold3(input logic [SCORE_W-1:0] s);
    for (int i = 0; i < 3; i++) begin
      drv(1'b0, 1'b0, s, 1); e.lu = 1'b0; e.to = 1'b0; e.hr = 1'b1;
      push($sformatf("hold%0d", i + 1));
    end
  endtask

  initial begin
    RST = '{lv:'0, hr:1'b0, rq:24'd1000, lu:1'b0, to:1'b0, gd:1'b0, tl:16'd3};
    rst_n = 1'b0; tick = 1'b0; restart = 1'b0; score = '0; xpos = '0; ypos = '0;
    e = RST;
    drv(0, 0, 0, 0); push("reset0");
    drv(0, 0, 0, 0); push("reset1");
    drv(0, 0, 0, 0); rst_n = 1'b1; push("release");

    // Score one short of requirement; restart in PLAY ignored
    drv(0, 1, 999, 1); push("no_adv_999");
    drv(0, 0, 1000, 1); e.lv = 1; e.rq = 24'd2000; e.lu = 1; e.hr = 1; push("adv_l0");
    hold3(1000);
    drv(0, 0, 1000, 1); e.hr = 0; push("hold_end0");

    // Countdown 3 -> 2 -> 1 -> expiry
    drv(1, 0, 0, 0); e.tl = 2; push("tick_3to2");
    drv(1, 0, 0, 0); e.tl = 1; push("tick_2to1");
    drv(0, 0, 0, 0); push("no_tick_hold");
    drv(1, 0, 0, 0); e.to = 1; e.tl = 3; e.hr = 1; push("expire");
    for (int i = 0; i < 3; i++) begin
      drv(1, 0, 0, 0); e.to = 0; push("hold_tick_ignored");
    end
    drv(1, 0, 0, 0); e.hr = 0; push("hold_end1");

    // Previous x off the exit blocks advance even with enough score
    drv(1, 0, 5000, 2); e.tl = 2; push("prev_x_mismatch_a");
    drv(1, 0, 5000, 2); e.tl = 1; push("prev_x_mismatch_b");
    // Exit together with expiring tick: exit wins
    drv(1, 0, 5000, 1); e.lv = 2; e.rq = 24'd6000; e.lu = 1; e.hr = 1; push("exit_vs_expire");
    hold3(5000);
    drv(0, 0, 5000, 1); e.hr = 0; e.tl = 3; push("hold_end2");

    // Saturating requirement
    drv(0, 0, 24'hFFFF00, 1); e.lv = 3; e.rq = 24'hFFFFFF; e.lu = 1; e.hr = 1; push("adv_sat");
    hold3(24'hFFFF00);
    drv(0, 0, 24'hFFFF00, 1); e.hr = 0; push("hold_end3");

    // Clearing the final level
    drv(0, 0, 24'hFFFFFF, 1); e.lu = 1; e.gd = 1; e.hr = 1; push("final_clear");
    drv(1, 0, 24'hFFFFFF, 1); e.lu = 0; e.hr = 0; push("complete");
    drv(1, 0, 24'hFFFFFF, 1); push("complete_frozen");
    drv(0, 1, 500, 1); e.lv = 0; e.rq = 24'd1500; e.gd = 0; e.hr = 1; push("restart");
    hold3(500);
    drv(0, 0, 500, 1); e.hr = 0; push("hold_end4");

    // Async reset in the middle of HOLD
    drv(0, 0, 1500, 1); e.lv = 1; e.rq = 24'd2500; e.lu = 1; e.hr = 1; push("adv_after_restart");
    drv(0, 0, 1500, 1); e.lu = 0; push("hold_pre_reset");
    @(negedge clk); #1;
    rst_n = 1'b0; #1;
    e = RST; push("async_reset"); ->chk_ev;
    drv(0, 0, 1500, 1); push("in_reset");
    drv(0, 0, 0, 0); rst_n = 1'b1; push("release2");
    drv(1, 0, 0, 0); e.tl = 2; push("tick_after_reset");

    repeat (3) @(negedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
